// File: rtl/bus_responder_if.sv
// CPU-side bus bundle for bus_responder: request fields driven by the CPU (master),
// response strobe/data and busy returned by the memory responder (slave).
interface bus_responder_if;
  logic        cpu_valid;
  logic        cpu_write;
  logic [15:0] address;
  logic [7:0]  cpu_data_out;
  logic [7:0]  data_in;
  logic        ready;
  logic        busy;

  modport master (
    output cpu_valid, cpu_write, address, cpu_data_out,
    input  data_in, ready, busy
  );

  modport slave (
    input  cpu_valid, cpu_write, address, cpu_data_out,
    output data_in, ready, busy
  );
endinterface

// File: rtl/bus_responder.sv
// Memory responder for the hmc-6502 CPU bus: byte array with ROM window, reset vector
// and programmable wait states. Define BUS_RESPONDER_ERR_EN to add the sticky bus_err output.
module bus_responder #(
  parameter int          MEM_AW      = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] ROM_BASE    = 16'hF000,
  parameter logic [15:0] RESET_VEC   = 16'hF000
) (
  input  logic           ph1,
  input  logic           reset,
  bus_responder_if.slave bus
`ifdef BUS_RESPONDER_ERR_EN
  ,
  output logic           bus_err
`endif
);

  localparam int          DEPTH   = 1 << MEM_AW;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("bus_responder: WAIT_STATES=%0d outside legal range 0..15", WAIT_STATES);
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_data_in;
  logic        r_ready;
  logic        r_busy;
  logic [7:0]  r_mem [0:DEPTH-1];

  logic        w_cap_blocked;
  logic        w_mem_we;
  logic        w_accept;
  logic [15:0] w_rd_addr;
  logic        w_rd_write;
  logic [7:0]  w_rd_data;

  // Writes to the vector bytes or anywhere in the ROM window never reach the array.
  assign w_cap_blocked = (r_addr == 16'hFFFC) || (r_addr == 16'hFFFD) || (r_addr >= ROM_BASE);
  assign w_mem_we      = (r_state == S_RESP) && r_write && !w_cap_blocked;
  assign w_accept      = bus.cpu_valid && ((r_state == S_IDLE) || (r_state == S_RESP));

  // Response data is formed on the edge entering RESP. With zero wait states that edge is
  // the accept edge, so the live bus address is used and an in-flight write is forwarded.
  always_comb begin
    w_rd_addr  = (r_state == S_WAIT) ? r_addr  : bus.address;
    w_rd_write = (r_state == S_WAIT) ? r_write : bus.cpu_write;
    w_rd_data  = r_mem[w_rd_addr[MEM_AW-1:0]];
    if (w_mem_we && (w_rd_addr[MEM_AW-1:0] == r_addr[MEM_AW-1:0])) begin
      w_rd_data = r_wdata;
    end
    if (w_rd_addr == 16'hFFFC) begin
      w_rd_data = RESET_VEC[7:0];
    end else if (w_rd_addr == 16'hFFFD) begin
      w_rd_data = RESET_VEC[15:8];
    end
    if (w_rd_write) begin
      w_rd_data = 8'h00;
    end
  end

  always_ff @(posedge ph1) begin
    if (w_mem_we) begin
      r_mem[r_addr[MEM_AW-1:0]] <= r_wdata;
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_data_in <= 8'h00;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ready   <= 1'b0;
      r_data_in <= 8'h00;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_write <= bus.cpu_write;
            r_addr  <= bus.address;
            r_wdata <= bus.cpu_data_out;
            r_busy  <= 1'b1;
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WS_LOAD;
            end else begin
              r_state   <= S_RESP;
              r_ready   <= 1'b1;
              r_data_in <= w_rd_data;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state   <= S_RESP;
            r_ready   <= 1'b1;
            r_data_in <= w_rd_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_RESPONDER_ERR_EN
  logic r_bus_err;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else if ((r_state == S_RESP) && r_write && w_cap_blocked) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`endif

  assign bus.data_in = r_data_in;
  assign bus.ready   = r_ready;
  assign bus.busy    = r_busy;

endmodule
